// File: rtl/multiword_add_sequencer.sv
// Multi-precision add/subtract sequencer: streams 8-bit operand slices LSB-first
// into an external registered adder and reassembles the full-width result.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for an operand request, in_ready=1
// S_ISSUE  | driving slice k to the adder, collecting slice k-1 sum
// S_DRAIN  | adder idle, collecting top slice sum, carry and overflow
// S_DONE   | result valid, waiting for out_ready
module multiword_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*WORDS-1:0]   in_a,
    input  logic [8*WORDS-1:0]   in_b,
    input  logic                 in_cin,
    input  logic                 in_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*WORDS-1:0]   out_sum,
    output logic                 out_cout,
    output logic                 out_ovf,
    output logic [7:0]           add_a,
    output logic [7:0]           add_b,
    output logic                 add_cin,
    input  logic [7:0]           add_sum,
    input  logic                 add_cout
);

    localparam int KW = $clog2(WORDS);
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [WORDS-1:0][7:0] a_q, a_d;
    logic [WORDS-1:0][7:0] b_q, b_d;
    logic [WORDS-1:0][7:0] sum_q, sum_d;
    logic                  carry0_q, carry0_d;
    logic [KW-1:0]         k_q, k_d;
    logic                  cout_q, cout_d;
    logic                  ovf_q, ovf_d;
    logic [KW-1:0]         k_prev;

    assign k_prev = k_q - KW'(1);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        carry0_d = carry0_q;
        k_d      = k_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        add_a    = 8'h00;
        add_b    = 8'h00;
        add_cin  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // B is stored pre-inverted so subtract is just add with carry0=1
                    a_d      = in_a;
                    b_d      = in_b ^ {(8*WORDS){in_sub}};
                    carry0_d = in_sub | in_cin;
                    k_d      = '0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                add_a   = a_q[k_q];
                add_b   = b_q[k_q];
                // adder outputs lag one cycle, so add_cout is the carry of slice k-1
                add_cin = (k_q == '0) ? carry0_q : add_cout;
                if (k_q != '0) begin
                    sum_d[k_prev] = add_sum;
                end
                if (k_q == K_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DRAIN: begin
                sum_d[WORDS-1] = add_sum;
                cout_d         = add_cout;
                ovf_d          = (a_q[WORDS-1][7] == b_q[WORDS-1][7]) &&
                                 (add_sum[7] != a_q[WORDS-1][7]);
                state_d        = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            carry0_q <= 1'b0;
            k_q      <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            carry0_q <= carry0_d;
            k_q      <= k_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer (WORDS=4) with a registered 8-bit
// adder model attached to the slice ports.
module tb_multiword_add_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_sum;
    logic        add_cout;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] a_seen [4];
    logic [7:0] b_seen [4];
    logic       cin_seen [4];
    logic       drain_zero;

    multiword_add_sequencer #(.WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (rst) begin
            add_sum  <= 8'h00;
            add_cout <= 1'b0;
        end else begin
            {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one op, records adder-port activity, checks latency and result,
    // holds out_ready low for 'hold' cycles, then accepts the result.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, input logic [31:0] es,
                          input logic ec, input logic eo, input int hold);
        int cnt;
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
        chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = ~a; in_b = ~b; in_cin = ~cin; in_sub = ~sub;
        cnt = 1;
        drain_zero = 1'b0;
        while (!out_valid && cnt < 20) begin
            if (cnt <= 4) begin
                a_seen[cnt-1]   = add_a;
                b_seen[cnt-1]   = add_b;
                cin_seen[cnt-1] = add_cin;
            end
            if (cnt == 5)
                drain_zero = (add_a == 8'h00) && (add_b == 8'h00) && (add_cin == 1'b0);
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, " latency"}, 64'(cnt), 64'd6);
        chk({tag, " sum"}, 64'(out_sum), 64'(es));
        chk({tag, " cout"}, 64'(out_cout), 64'(ec));
        chk({tag, " ovf"}, 64'(out_ovf), 64'(eo));
        chk({tag, " drain adder inputs zero"}, 64'(drain_zero), 64'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, " hold valid"}, 64'(out_valid), 64'd1);
            chk({tag, " hold sum"}, 64'(out_sum), 64'(es));
            chk({tag, " hold in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " valid dropped"}, 64'(out_valid), 64'd0);
        chk({tag, " back to idle"}, 64'(in_ready), 64'd1);
    endtask

    logic [31:0] op_a [2];
    logic [31:0] op_b [2];
    logic        op_s [2];
    logic [31:0] res_exp [2];
    logic [31:0] res_got [2];
    int          res_cyc [2];

    initial begin
        int acc;
        int npulse;
        int cyc;

        rst = 1'b1; in_valid = 1'b1; in_a = 32'h1234_5678; in_b = 32'h1;
        in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("reset in_ready", 64'(in_ready), 64'd1);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_sum", 64'(out_sum), 64'd0);
        chk("reset out_cout", 64'(out_cout), 64'd0);
        chk("reset out_ovf", 64'(out_ovf), 64'd0);
        chk("reset adder inputs", {47'd0, add_a, add_b, add_cin}, 64'd0);

        run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
               32'h0000_0000, 1'b1, 1'b0, 0);

        run_op("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1,
               32'hFFFF_FFFE, 1'b0, 1'b0, 0);
        chk("sub add_b slice0", 64'(b_seen[0]), 64'hF8);
        chk("sub add_cin first", 64'(cin_seen[0]), 64'd1);

        run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0,
               32'h8000_0000, 1'b0, 1'b1, 0);
        run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1,
               32'h7FFF_FFFF, 1'b1, 1'b1, 0);

        run_op("chain", 32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0,
               32'h0100_0101, 1'b0, 1'b0, 0);
        chk("chain add_cin seq", 64'({cin_seen[0], cin_seen[1], cin_seen[2], cin_seen[3]}),
            64'b1101);
        chk("chain add_a seq", 64'({a_seen[3], a_seen[2], a_seen[1], a_seen[0]}),
            64'h00FF_00FF);

        run_op("backpressure", 32'h1234_0000, 32'h0000_4321, 1'b0, 1'b0,
               32'h1234_4321, 1'b0, 1'b0, 5);

        // Back-to-back: in_valid and out_ready both held high
        op_a[0] = 32'h1234_5678; op_b[0] = 32'h1111_1111; op_s[0] = 1'b0;
        res_exp[0] = 32'h2345_6789;
        op_a[1] = 32'h1000_0000; op_b[1] = 32'h0000_0001; op_s[1] = 1'b1;
        res_exp[1] = 32'h0FFF_FFFF;
        res_got[0] = '0; res_got[1] = '0; res_cyc[0] = 0; res_cyc[1] = 0;
        acc = 0; npulse = 0; cyc = 0;
        in_cin = 1'b0;
        out_ready = 1'b1;
        while (npulse < 2 && cyc < 60) begin
            if (out_valid) begin
                res_got[npulse] = out_sum;
                res_cyc[npulse] = cyc;
                npulse++;
            end
            if (in_ready) begin
                if (acc < 2) begin
                    in_a = op_a[acc]; in_b = op_b[acc]; in_sub = op_s[acc];
                    in_valid = 1'b1;
                    acc++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("b2b pulse count", 64'(npulse), 64'd2);
        chk("b2b result0", 64'(res_got[0]), 64'(res_exp[0]));
        chk("b2b result1", 64'(res_got[1]), 64'(res_exp[1]));
        chk("b2b spacing", 64'(res_cyc[1] - res_cyc[0]), 64'd7);

        // Reset while issuing slice k=2
        in_a = 32'h1111_1111; in_b = 32'h2222_2222; in_sub = 1'b0; in_cin = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre-reset add_a k2", 64'(add_a), 64'h11);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort in_ready", 64'(in_ready), 64'd1);
        chk("abort out_valid", 64'(out_valid), 64'd0);
        chk("abort out_sum", 64'(out_sum), 64'd0);
        chk("abort adder inputs", {47'd0, add_a, add_b, add_cin}, 64'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort no valid", 64'(out_valid), 64'd0);
        end

        run_op("after_abort", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
